// File: rtl/master_req_gen_if.sv
// Bus-side signals between the request generator and the master port.
interface master_req_gen_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  busy;
    logic                  o_start;
    logic                  o_rw;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_wdata;
    logic                  o_active;
    logic                  o_dropped;
    logic                  o_err;

    modport master (
        input  busy,
        output o_start, o_rw, o_addr, o_wdata, o_active, o_dropped, o_err
    );

    modport slave (
        output busy,
        input  o_start, o_rw, o_addr, o_wdata, o_active, o_dropped, o_err
    );
endinterface

// File: rtl/master_req_gen.sv
// Turns debounced push-button presses into single bus transactions:
// button1 issues a write, button2 a read of the last written address.
// A one-entry slot queues one press that arrives while the port is in use.
module master_req_gen #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int DEB_CYCLES    = 1,
    parameter int START_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button1,
    input  logic             button2,
    master_req_gen_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 2);

    // Index 0 is the write button, index 1 the read button.
    logic [1:0]      btn;
    logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]      deb_q, deb_d, ev_q, ev_d;
    logic [1:0][7:0] deb_cnt_q, deb_cnt_d;

    state_t                state_q, state_d;
    logic                  launch, launch_rw, timeout, done;
    logic                  start, active;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, wr_ptr_q, wr_ptr_d, last_wr_addr_q, last_wr_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_cnt_q, data_cnt_d;
    logic                  slot_vld_q, slot_vld_d, slot_rw_q, slot_rw_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  drop_q, drop_d, err_q, err_d;

    assign btn = {button2, button1};

    // Synchronize, debounce and detect the falling (press) edge of each button.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sync1_d   = btn;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
                else                          deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
            end
        end
        ev_d = deb_q & ~deb_d;
    end

    // Input-stage registers; buttons idle high, so the chain resets to 1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            deb_q     <= '1;
            deb_cnt_q <= '0;
            ev_q      <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            ev_q      <= ev_d;
        end
    end

    // Launch only from IDLE with the port free; a busy port holds requests off.
    assign launch  = (state_q == IDLE) && !bus.busy && (slot_vld_q || ev_q[0] || ev_q[1]);
    assign timeout = (state_q == WAIT_BUSY) && !bus.busy && (tmo_q == TMO_LAST);
    assign done    = (state_q == WAIT_DONE) && !bus.busy;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (launch) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (bus.busy) state_d = WAIT_DONE;
                       else if (timeout) state_d = IDLE;
            WAIT_DONE: if (!bus.busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs: start pulse in ISSUE, active for the whole transaction.
    always_comb begin
        start  = (state_q == ISSUE);
        active = (state_q != IDLE);
    end

    // Request latching, pending slot, counters and error/drop pulses.
    always_comb begin
        rw_d           = rw_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wr_ptr_d       = wr_ptr_q;
        data_cnt_d     = data_cnt_q;
        last_wr_addr_d = last_wr_addr_q;
        slot_vld_d     = slot_vld_q;
        slot_rw_d      = slot_rw_q;
        drop_d         = 1'b0;
        err_d          = timeout;
        tmo_d          = (state_q == WAIT_BUSY) ? tmo_q + 8'd1 : 8'd0;
        launch_rw      = 1'b0;

        if (launch) begin
            if (slot_vld_q) begin
                // Slot wins; any new event refills the slot, write before read.
                launch_rw  = slot_rw_q;
                slot_vld_d = ev_q[0] || ev_q[1];
                slot_rw_d  = ev_q[0];
                drop_d     = ev_q[0] && ev_q[1];
            end else if (ev_q[0]) begin
                launch_rw  = 1'b1;
                slot_vld_d = ev_q[1];
                slot_rw_d  = 1'b0;
            end else begin
                launch_rw  = 1'b0;
            end
            rw_d    = launch_rw;
            addr_d  = launch_rw ? wr_ptr_q : last_wr_addr_q;
            wdata_d = data_cnt_q;
        end else if (ev_q[0] || ev_q[1]) begin
            if (!slot_vld_q) begin
                slot_vld_d = 1'b1;
                slot_rw_d  = ev_q[0];
                drop_d     = ev_q[0] && ev_q[1];
            end else begin
                drop_d     = 1'b1;
            end
        end

        if (done && rw_q) begin
            wr_ptr_d       = wr_ptr_q + ADDR_WIDTH'(1);
            data_cnt_d     = data_cnt_q + DATA_WIDTH'(1);
            last_wr_addr_d = addr_q;
        end
    end

    // Datapath registers; reset aborts any transaction without side effects.
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wr_ptr_q       <= '0;
            data_cnt_q     <= DATA_WIDTH'(1);
            last_wr_addr_q <= '0;
            slot_vld_q     <= 1'b0;
            slot_rw_q      <= 1'b0;
            tmo_q          <= '0;
            drop_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            rw_q           <= rw_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wr_ptr_q       <= wr_ptr_d;
            data_cnt_q     <= data_cnt_d;
            last_wr_addr_q <= last_wr_addr_d;
            slot_vld_q     <= slot_vld_d;
            slot_rw_q      <= slot_rw_d;
            tmo_q          <= tmo_d;
            drop_q         <= drop_d;
            err_q          <= err_d;
        end
    end

    assign bus.o_start   = start;
    assign bus.o_active  = active;
    assign bus.o_rw      = rw_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_wdata   = wdata_q;
    assign bus.o_dropped = drop_q;
    assign bus.o_err     = err_q;
endmodule

// File: tb/tb_master_req_gen.sv
// Scoreboard bench: expected transactions are queued when a press is issued
// and a monitor pops and compares them on every o_start.
module tb_master_req_gen;
    typedef struct {
        bit        rw;
        bit [11:0] addr;
        bit [7:0]  wdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button1 = 1'b1, button2 = 1'b1;
    logic d_button1 = 1'b1, d_button2 = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int drop_cnt = 0;
    int err_cnt = 0;
    int start_cyc = 0;
    int start2_cnt = 0;
    bit resp_en = 1'b1;
    exp_t exp_q[$];
    exp_t snap;

    master_req_gen_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();
    master_req_gen_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus2 ();

    master_req_gen dut (
        .clk(clk), .reset(reset), .button1(button1), .button2(button2), .bus(bus.master)
    );

    master_req_gen #(.DEB_CYCLES(4)) dut_deb (
        .clk(clk), .reset(reset), .button1(d_button1), .button2(d_button2), .bus(bus2.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Slave model: busy rises 3 cycles after o_start and stays high 10 cycles.
    initial begin
        bus.busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_start && resp_en && !reset) begin
                repeat (3) @(negedge clk);
                bus.busy = 1'b1;
                repeat (10) @(negedge clk);
                bus.busy = 1'b0;
            end
        end
    end

    // The debounce instance never sees busy; only its starts are counted.
    initial bus2.busy = 1'b0;

    // Monitor: pops the scoreboard on o_start, checks hold-stability and pulses.
    always @(negedge clk) begin
        cyc++;
        if (bus2.o_start) start2_cnt++;
        if (!reset) begin
            if (bus.o_start) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_start");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("start_rw", 32'(bus.o_rw), 32'(e.rw));
                    check("start_addr", 32'(bus.o_addr), 32'(e.addr));
                    if (e.rw) check("start_wdata", 32'(bus.o_wdata), 32'(e.wdata));
                    check("start_active", 32'(bus.o_active), 32'd1);
                end
                start_cyc  = cyc;
                snap.rw    = bus.o_rw;
                snap.addr  = bus.o_addr;
                snap.wdata = bus.o_wdata;
            end else if (bus.o_active) begin
                check("hold_rw", 32'(bus.o_rw), 32'(snap.rw));
                check("hold_addr", 32'(bus.o_addr), 32'(snap.addr));
                if (snap.rw) check("hold_wdata", 32'(bus.o_wdata), 32'(snap.wdata));
            end
            if (bus.o_dropped) drop_cnt++;
            if (bus.o_err) begin
                err_cnt++;
                check("err_delay", 32'(cyc - start_cyc), 32'd16);
                check("err_active", 32'(bus.o_active), 32'd0);
            end
        end
    end

    task automatic push(input bit rw, input bit [11:0] addr, input bit [7:0] wdata);
        exp_t e;
        e.rw = rw; e.addr = addr; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    task automatic press(input bit b1, input bit b2, input int len);
        @(negedge clk);
        button1 = ~b1;
        button2 = ~b2;
        repeat (len) @(negedge clk);
        button1 = 1'b1;
        button2 = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !bus.o_active && !bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout_fail(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drop_cnt = 0;
        err_cnt  = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(bus.o_start), 32'd0);
        check("rst_active", 32'(bus.o_active), 32'd0);
        check("rst_rw", 32'(bus.o_rw), 32'd0);
        check("rst_addr", 32'(bus.o_addr), 32'd0);
        check("rst_wdata", 32'(bus.o_wdata), 32'd0);
        check("rst_flags", 32'({bus.o_dropped, bus.o_err}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single write, then read of the written address, then a write
        // showing data_cnt moved only once.
        push(1'b1, 12'h000, 8'h01);
        press(1'b1, 1'b0, 1);
        drain("single_write");
        push(1'b0, 12'h000, 8'h00);
        press(1'b0, 1'b1, 1);
        drain("read_after_write");
        push(1'b1, 12'h001, 8'h02);
        press(1'b1, 1'b0, 1);
        drain("write_after_read");
        check("drops_basic", 32'(drop_cnt), 32'd0);

        // Queueing: one launched, one slotted, one dropped.
        do_reset();
        push(1'b1, 12'h000, 8'h01);
        push(1'b1, 12'h001, 8'h02);
        press(1'b1, 1'b0, 1);
        n = 0;
        while (!bus.busy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("queue_busy_wait");
        button1 = 1'b0; @(negedge clk); button1 = 1'b1;
        repeat (3) @(negedge clk);
        button1 = 1'b0; @(negedge clk); button1 = 1'b1;
        drain("queueing");
        check("queue_drops", 32'(drop_cnt), 32'd1);

        // Start timeout, then a write that reuses the un-advanced counters.
        do_reset();
        resp_en = 1'b0;
        push(1'b1, 12'h000, 8'h01);
        press(1'b1, 1'b0, 1);
        n = 0;
        while (err_cnt == 0 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("err_wait");
        drain("timeout_drain");
        check("err_count", 32'(err_cnt), 32'd1);
        resp_en = 1'b1;
        push(1'b1, 12'h000, 8'h01);
        press(1'b1, 1'b0, 1);
        drain("after_timeout");

        // Debounce with DEB_CYCLES=4: a 3-cycle glitch is ignored.
        @(negedge clk); d_button1 = 1'b0;
        repeat (3) @(negedge clk); d_button1 = 1'b1;
        repeat (30) @(negedge clk);
        check("deb_glitch", 32'(start2_cnt), 32'd0);
        d_button1 = 1'b0;
        repeat (4) @(negedge clk); d_button1 = 1'b1;
        repeat (30) @(negedge clk);
        check("deb_pulse", 32'(start2_cnt), 32'd1);

        // Simultaneous presses: write first, read of address 0 second.
        do_reset();
        push(1'b1, 12'h000, 8'h01);
        push(1'b0, 12'h000, 8'h00);
        press(1'b1, 1'b1, 1);
        drain("simultaneous");
        check("simul_drops", 32'(drop_cnt), 32'd0);

        // Reset in WAIT_DONE aborts the write without advancing counters.
        push(1'b1, 12'h001, 8'h02);
        press(1'b1, 1'b0, 1);
        n = 0;
        while (!(bus.o_active && bus.busy) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("wait_done_wait");
        reset = 1'b1;
        @(negedge clk);
        check("abort_start", 32'(bus.o_start), 32'd0);
        check("abort_active", 32'(bus.o_active), 32'd0);
        check("abort_rw", 32'(bus.o_rw), 32'd0);
        check("abort_addr", 32'(bus.o_addr), 32'd0);
        check("abort_wdata", 32'(bus.o_wdata), 32'd0);
        check("abort_flags", 32'({bus.o_dropped, bus.o_err}), 32'd0);
        reset = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("busy_release_wait");
        check("abort_err", 32'(err_cnt), 32'd0);
        push(1'b1, 12'h000, 8'h01);
        press(1'b1, 1'b0, 1);
        drain("after_abort");
        check("leftover_exp", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/master_req_gen.md
MASTER_REQ_GEN -- requirements
Module: master_req_gen

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning the request address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the write-data width.
REQ-003 The block SHALL have parameter DEB_CYCLES, default 1, meaning the consecutive stable samples required to accept a button level change (range 1..255).
REQ-004 The block SHALL have parameter START_TIMEOUT, default 16, meaning the cycles allowed for busy to rise after a start (range 2..255).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 button1  input  1  async push button, active-low; a press requests a write.
REQ-008 button2  input  1  async push button, active-low; a press requests a read.
REQ-009 busy  input  1  master-port busy, high while a bus transaction is in progress.
REQ-010 o_start  output  1  one-cycle transaction start pulse to the master port.
REQ-011 o_rw  output  1  operation: 1=write, 0=read; valid while o_active.
REQ-012 o_addr  output  ADDR_WIDTH  transaction address; valid while o_active.
REQ-013 o_wdata  output  DATA_WIDTH  write data; valid while o_active and o_rw=1.
REQ-014 o_active  output  1  high from o_start through busy falling.
REQ-015 o_dropped  output  1  one-cycle pulse when a press event is discarded.
REQ-016 o_err  output  1  one-cycle pulse on start timeout.

Function
REQ-017 Each button SHALL pass a 2-flop synchronizer whose flops reset to 1.
REQ-018 Each debouncer SHALL update its debounced level only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any matching sample clears its counter.
REQ-019 A press event SHALL be a 1-to-0 transition of the debounced level, lasting exactly one cycle; releases generate no event.
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: on an event or a valid pending slot, latch op/address/data and go to ISSUE; the pending slot has priority over a new event, and a new event arriving that cycle goes to the slot.
REQ-022 ISSUE: assert o_start for exactly one cycle, set o_active, go to WAIT_BUSY.
REQ-023 WAIT_BUSY: on busy=1 go to WAIT_DONE; if busy stays 0 for START_TIMEOUT cycles after o_start, pulse o_err, clear o_active, go to IDLE, and do not advance counters.
REQ-024 WAIT_DONE: on busy=0 clear o_active, advance counters per REQ-026, go to IDLE.
REQ-025 o_addr, o_rw, o_wdata SHALL stay constant from ISSUE until o_active clears.
REQ-026 Write: o_addr=wr_ptr, o_wdata=data_cnt; on completion wr_ptr+1 and data_cnt+1, each wrapping modulo 2^width.
REQ-027 Read: o_addr=last_wr_addr (the address of the most recently completed write, 0 if none); no counter changes.
REQ-028 A one-entry pending slot SHALL hold one event (op only) raised while the FSM is not IDLE, or the second of two simultaneous events; when the slot is full, further events are discarded with o_dropped.
REQ-029 When both buttons produce events in the same cycle, the write SHALL be serviced first and the read SHALL be placed in the slot.
REQ-030 busy high while in IDLE SHALL be ignored, and no o_start SHALL be issued until busy=0.

Reset
REQ-031 On reset: FSM to IDLE; o_start, o_active, o_dropped, o_err, o_rw = 0; o_addr, o_wdata, wr_ptr, last_wr_addr = 0; data_cnt = 1; slot empty; synchronizers and debounced levels = 1; debounce counters = 0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately, with no o_err and no counter advance.

Verification
REQ-033 Single write: button1 low for 1 cycle, busy high 3 cycles after o_start for 10 cycles -> o_start once; o_rw=1, o_addr=0x000, o_wdata=0x01; o_active falls with busy; wr_ptr becomes 1.
REQ-034 Read after write: then button2 pressed once -> o_rw=0, o_addr=0x000; data_cnt stays 0x02.
REQ-035 Queueing: three button1 presses during one busy transaction -> the second press is queued and issued after busy falls; the third press gives one o_dropped pulse; two writes total (addresses 0x000, 0x001).
REQ-036 Timeout: button1 pressed, busy held 0 -> o_err 16 cycles after o_start; o_active=0; the next write still uses addr 0x000, data 0x01.
REQ-037 Debounce with DEB_CYCLES=4: a 3-cycle low glitch -> no event; a 4-cycle low pulse -> exactly one o_start.
REQ-038 Simultaneous presses plus reset: both buttons pressed together -> write then read, in that order; a reset asserted in WAIT_DONE -> all outputs go to reset values on the next cycle.
